// File: rtl/vga_timing_if.sv
// Raster/DAC output bundle of vga_timing_gen: DAC control pins, pixel coordinates,
// region phases and line/frame strobes. The master side drives, the pixel source listens.
interface vga_timing_if #(
    parameter int XW = 10,
    parameter int YW = 10
);
    logic          pix_en;
    logic          VGA_CLK;
    logic          VGA_HS;
    logic          VGA_VS;
    logic          VGA_BLANK_N;
    logic          VGA_SYNC_N;
    logic [XW-1:0] pix_x;
    logic [YW-1:0] pix_y;
    logic          active;
    logic [1:0]    h_phase;
    logic [1:0]    v_phase;
    logic          line_start;
    logic          frame_start;

    modport master (
        output pix_en, VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N,
               pix_x, pix_y, active, h_phase, v_phase, line_start, frame_start
    );

    modport slave (
        input  pix_en, VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N,
               pix_x, pix_y, active, h_phase, v_phase, line_start, frame_start
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: pixel-rate enable, h/v counters, sync/blank decode.
// Optional VGA_PREFETCH_EN delays the DAC pins and phases by one pixel behind the coordinates.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CLK_DIV  = 2,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int XW       = 10,
    parameter int YW       = 10
) (
    input  logic         CLOCK_50,
    input  logic         RESET,
    vga_timing_if.master vga
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW      = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FP     = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BP     = 2'd3
    } phase_e;

    logic [DW-1:0] div_cnt_reg, div_cnt_next;
    logic [XW-1:0] h_cnt_reg, h_cnt_next;
    logic [YW-1:0] v_cnt_reg, v_cnt_next;
    phase_e        h_phase_reg, h_phase_next;
    phase_e        v_phase_reg, v_phase_next;
    logic          pix_en_reg, vga_clk_reg;
    logic          hs_reg, vs_reg, active_reg;
    logic          line_start_reg, frame_start_reg;
    logic          tick;

    // The counters advance on the last divider cycle, i.e. the cycle pix_en_reg is high.
    assign tick = (div_cnt_reg == DW'(CLK_DIV - 1));

    always_comb begin
        div_cnt_next = tick ? '0 : div_cnt_reg + 1'b1;
        h_cnt_next   = h_cnt_reg;
        v_cnt_next   = v_cnt_reg;
        if (tick) begin
            if (h_cnt_reg == XW'(H_TOTAL - 1)) begin
                h_cnt_next = '0;
                v_cnt_next = (v_cnt_reg == YW'(V_TOTAL - 1)) ? '0 : v_cnt_reg + 1'b1;
            end else begin
                h_cnt_next = h_cnt_reg + 1'b1;
            end
        end
    end

    always_comb begin
        h_phase_next = PH_BP;
        if (h_cnt_next < XW'(H_ACTIVE))
            h_phase_next = PH_ACTIVE;
        else if (h_cnt_next < XW'(H_ACTIVE + H_FP))
            h_phase_next = PH_FP;
        else if (h_cnt_next < XW'(H_ACTIVE + H_FP + H_SYNC))
            h_phase_next = PH_SYNC;

        v_phase_next = PH_BP;
        if (v_cnt_next < YW'(V_ACTIVE))
            v_phase_next = PH_ACTIVE;
        else if (v_cnt_next < YW'(V_ACTIVE + V_FP))
            v_phase_next = PH_FP;
        else if (v_cnt_next < YW'(V_ACTIVE + V_FP + V_SYNC))
            v_phase_next = PH_SYNC;
    end

    // Outputs are registered from the next-state values so they describe the new counts.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            div_cnt_reg     <= '0;
            h_cnt_reg       <= XW'(H_TOTAL - 1);
            v_cnt_reg       <= YW'(V_TOTAL - 1);
            h_phase_reg     <= PH_BP;
            v_phase_reg     <= PH_BP;
            pix_en_reg      <= 1'b0;
            vga_clk_reg     <= 1'b0;
            hs_reg          <= ~HS_POL;
            vs_reg          <= ~VS_POL;
            active_reg      <= 1'b0;
            line_start_reg  <= 1'b0;
            frame_start_reg <= 1'b0;
        end else begin
            div_cnt_reg     <= div_cnt_next;
            h_cnt_reg       <= h_cnt_next;
            v_cnt_reg       <= v_cnt_next;
            h_phase_reg     <= h_phase_next;
            v_phase_reg     <= v_phase_next;
            pix_en_reg      <= (div_cnt_next == DW'(CLK_DIV - 1));
            vga_clk_reg     <= (div_cnt_next >= DW'(CLK_DIV / 2));
            hs_reg          <= (h_phase_next == PH_SYNC) ? HS_POL : ~HS_POL;
            vs_reg          <= (v_phase_next == PH_SYNC) ? VS_POL : ~VS_POL;
            active_reg      <= (h_phase_next == PH_ACTIVE) && (v_phase_next == PH_ACTIVE);
            line_start_reg  <= tick && (h_cnt_next == '0);
            frame_start_reg <= tick && (h_cnt_next == '0) && (v_cnt_next == '0);
        end
    end

    assign vga.pix_en      = pix_en_reg;
    assign vga.VGA_CLK     = vga_clk_reg;
    assign vga.VGA_SYNC_N  = 1'b0;
    assign vga.pix_x       = h_cnt_reg;
    assign vga.pix_y       = v_cnt_reg;
    assign vga.active      = active_reg;
    assign vga.line_start  = line_start_reg;
    assign vga.frame_start = frame_start_reg;

`ifdef VGA_PREFETCH_EN
    // DAC-facing stage lags the coordinates by one pixel to hide framebuffer read latency.
    logic   hs_dly_reg, vs_dly_reg, blank_n_dly_reg;
    phase_e h_phase_dly_reg, v_phase_dly_reg;

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            hs_dly_reg      <= ~HS_POL;
            vs_dly_reg      <= ~VS_POL;
            blank_n_dly_reg <= 1'b0;
            h_phase_dly_reg <= PH_BP;
            v_phase_dly_reg <= PH_BP;
        end else if (tick) begin
            hs_dly_reg      <= hs_reg;
            vs_dly_reg      <= vs_reg;
            blank_n_dly_reg <= active_reg;
            h_phase_dly_reg <= h_phase_reg;
            v_phase_dly_reg <= v_phase_reg;
        end
    end

    assign vga.VGA_HS      = hs_dly_reg;
    assign vga.VGA_VS      = vs_dly_reg;
    assign vga.VGA_BLANK_N = blank_n_dly_reg;
    assign vga.h_phase     = h_phase_dly_reg;
    assign vga.v_phase     = v_phase_dly_reg;
`else
    assign vga.VGA_HS      = hs_reg;
    assign vga.VGA_VS      = vs_reg;
    assign vga.VGA_BLANK_N = active_reg;
    assign vga.h_phase     = h_phase_reg;
    assign vga.v_phase     = v_phase_reg;
`endif
endmodule
